// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the DMEM read arbiter.
// FSM state encoding, default parameters, counter/index width helpers.
package dmem_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

  function automatic int idx_w(input int num_req);
    return $clog2(num_req);
  endfunction

endpackage

// File: rtl/dmem_rd_arbiter_rr_picker.sv
// Round-robin picker: first asserted req at or after rr_ptr, wrapping.
// Ports: req, rr_ptr in; any, idx out. Purely combinational.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);

  localparam int DW = IW + 1;

  logic [DW-1:0] d;
  logic [DW-1:0] best;

  // Smallest wrapped distance from rr_ptr wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    best = '1;
    d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (DW'(i) >= DW'(rr_ptr))
        d = DW'(i) - DW'(rr_ptr);
      else
        d = DW'(i) + DW'(NUM_REQ) - DW'(rr_ptr);
      if (req[i] && (!any || d < best)) begin
        any  = 1'b1;
        best = d;
        idx  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dmem_rd_arbiter.sv
// Round-robin arbiter sharing one DMEM read port among NUM_REQ requesters.
// Ports: req/req_addr in, gnt/rsp_* out, mem_* to/from DMEM; all outputs registered.
module dmem_rd_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      mem_read_enable,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_read_data,
  input  logic                      mem_data_ready
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam int IW = idx_w(NUM_REQ);

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          tmo;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (pick_any) nxt = WAIT;
      WAIT:    if (mem_data_ready || tmo) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath; data beats timeout in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt             <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      mem_read_enable <= 1'b0;
      mem_addr        <= '0;
      rr_ptr          <= '0;
      idx             <= '0;
      cnt             <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            idx             <= pick_idx;
            gnt             <= NUM_REQ'(1) << pick_idx;
            mem_addr        <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_read_enable <= 1'b1;
            cnt             <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (mem_data_ready) begin
            rsp_data        <= mem_read_data;
            rsp_err         <= 1'b0;
            rsp_valid       <= NUM_REQ'(1) << idx;
            mem_read_enable <= 1'b0;
          end else if (tmo) begin
            rsp_data        <= '0;
            rsp_err         <= 1'b1;
            rsp_valid       <= NUM_REQ'(1) << idx;
            mem_read_enable <= 1'b0;
          end
        end
        RESP: begin
          cnt    <= '0;
          rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
